// File: rtl/ctrl_types.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_types (package)
// Description : Shared types and widths for the pipeline sequencing control.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_types;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  // RUN     : normal sequencing
  // IWAIT   : instruction fetch miss outstanding
  // ISQUASH : fetch miss outstanding with a redirect waiting for it to finish
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IWAIT   = 2'd1,
    ISQUASH = 2'd2
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard comparator between the ID
//               instruction's sources and the load currently in EX.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
  import ctrl_types::*;
(
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  output logic             lu
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never a real producer, so a load targeting it cannot create a hazard
  always_comb begin
    w_rs1_hit = id_uses_rs1 && (ifid_rs1 == idex_rd);
    w_rs2_hit = id_uses_rs2 && (ifid_rs2 == idex_rd);
    lu        = idex_mem_read && (idex_rd != '0) && (w_rs1_hit || w_rs2_hit);
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing controller for the five-stage RV32I core.
//               Chooses register enables, bubbles and PC redirects, deferring
//               a redirect that lands during an outstanding fetch miss.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import ctrl_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             ex_br_taken,
  input  logic [XLEN-1:0]  ex_br_target,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_access,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exmem,
  output logic             load_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  pc_redirect_addr,
  output logic [XLEN-1:0]  stall_count,
  output logic [XLEN-1:0]  flush_count
);

  hz_state_t       state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] stall_count_q, stall_count_d;
  logic [XLEN-1:0] flush_count_q, flush_count_d;

  logic w_lu;
  logic w_imiss;
  logic w_dfreeze;

  load_use_detect u_lu (
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .lu            (w_lu)
  );

  assign w_imiss   = imem_read && !imem_resp;
  assign w_dfreeze = dmem_access && !dmem_resp;

  // Priority-ordered sequencing decision and FSM next state
  always_comb begin
    load_pc          = 1'b1;
    load_ifid        = 1'b1;
    load_idex        = 1'b1;
    load_exmem       = 1'b1;
    load_memwb       = 1'b1;
    flush_ifid       = 1'b0;
    flush_idex       = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    state_d          = state_q;
    target_d         = target_q;

    if (rst) begin
      load_pc    = 1'b0;
      load_ifid  = 1'b0;
      load_idex  = 1'b0;
      load_exmem = 1'b0;
      load_memwb = 1'b0;
    end else if (w_dfreeze) begin
      // Whole pipe holds; EX re-presents any branch and the I-cache retries.
      load_pc    = 1'b0;
      load_ifid  = 1'b0;
      load_idex  = 1'b0;
      load_exmem = 1'b0;
      load_memwb = 1'b0;
    end else if (state_q == ISQUASH) begin
      // Keep squashing fetch until the stale fetch drains, then redirect.
      flush_ifid = 1'b1;
      if (imem_resp) begin
        pc_redirect      = 1'b1;
        pc_redirect_addr = target_q;
        state_d          = RUN;
      end else begin
        load_pc = 1'b0;
      end
    end else if (ex_br_taken) begin
      // Redirect wins over load-use: the ID instruction is squashed anyway.
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      if (!w_imiss) begin
        pc_redirect      = 1'b1;
        pc_redirect_addr = ex_br_target;
        state_d          = RUN;
      end else begin
        load_pc  = 1'b0;
        target_d = ex_br_target;
        state_d  = ISQUASH;
      end
    end else begin
      if (w_lu) begin
        load_pc    = 1'b0;
        load_ifid  = 1'b0;
        flush_idex = 1'b1;
      end else if (w_imiss) begin
        load_pc    = 1'b0;
        flush_ifid = 1'b1;
      end
      state_d = w_imiss ? IWAIT : RUN;
    end
  end

  // Performance counters, free-running and wrapping
  always_comb begin
    stall_count_d = stall_count_q + {{(XLEN-1){1'b0}}, ~load_pc};
    flush_count_d = flush_count_q + {{(XLEN-1){1'b0}}, pc_redirect};
  end

  // State, deferred target and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      target_q      <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl using a per-cycle
//               expected-output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
  import ctrl_types::*;

  // Control vector order: load_pc, load_ifid, load_idex, load_exmem,
  // load_memwb, flush_ifid, flush_idex, pc_redirect
  localparam logic [7:0] C_OFF   = 8'b00000_00_0;
  localparam logic [7:0] C_DEF   = 8'b11111_00_0;
  localparam logic [7:0] C_LU    = 8'b00111_01_0;
  localparam logic [7:0] C_BR    = 8'b11111_11_1;
  localparam logic [7:0] C_BRMS  = 8'b01111_11_0;
  localparam logic [7:0] C_SQW   = 8'b01111_10_0;
  localparam logic [7:0] C_SQR   = 8'b11111_10_1;
  localparam logic [7:0] C_IMISS = 8'b01111_10_0;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        mr;
    logic [4:0]  rd;
    logic        br;
    logic [31:0] tgt;
    logic        ir;
    logic        iresp;
    logic        da;
    logic        dresp;
  } stim_t;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] addr;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
  logic        id_uses_rs1, id_uses_rs2, idex_mem_read;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        imem_read, imem_resp, dmem_access, dmem_resp;
  logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic        flush_ifid, flush_idex, pc_redirect;
  logic [31:0] pc_redirect_addr, stall_count, flush_count;

  logic [7:0]  ctrl_vec;
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  assign ctrl_vec = {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
                     flush_ifid, flush_idex, pc_redirect};

  hazard_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .ifid_rs1         (ifid_rs1),
    .ifid_rs2         (ifid_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .idex_mem_read    (idex_mem_read),
    .idex_rd          (idex_rd),
    .ex_br_taken      (ex_br_taken),
    .ex_br_target     (ex_br_target),
    .imem_read        (imem_read),
    .imem_resp        (imem_resp),
    .dmem_access      (dmem_access),
    .dmem_resp        (dmem_resp),
    .load_pc          (load_pc),
    .load_ifid        (load_ifid),
    .load_idex        (load_idex),
    .load_exmem       (load_exmem),
    .load_memwb       (load_memwb),
    .flush_ifid       (flush_ifid),
    .flush_idex       (flush_idex),
    .pc_redirect      (pc_redirect),
    .pc_redirect_addr (pc_redirect_addr),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  // EX holds bubbles while a redirect is pending, so a branch here is illegal
  always @(posedge clk) begin
    if (!rst && dut.state_q == ISQUASH && ex_br_taken) begin
      $display("FAIL isquash_branch: ex_br_taken=1 while state=ISQUASH, required 0");
      n_fail++;
    end
  end

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic br,
                               input logic [31:0] tgt, input logic ir,
                               input logic iresp, input logic da,
                               input logic dresp);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.mr = mr; s.rd = rd;
    s.br = br; s.tgt = tgt; s.ir = ir; s.iresp = iresp; s.da = da;
    s.dresp = dresp;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    ifid_rs1      = s.rs1;
    ifid_rs2      = s.rs2;
    id_uses_rs1   = s.u1;
    id_uses_rs2   = s.u2;
    idex_mem_read = s.mr;
    idex_rd       = s.rd;
    ex_br_taken   = s.br;
    ex_br_target  = s.tgt;
    imem_read     = s.ir;
    imem_resp     = s.iresp;
    dmem_access   = s.da;
    dmem_resp     = s.dresp;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 32'h60, 0, 0, 0, 0));
    exp_q.push_back('{C_OFF, 32'h0, "reset_outputs"});
    #2;
    e = exp_q.pop_front();
    n_checks++;
    if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
      $display("FAIL %s: got ctrl=%b addr=%h, required ctrl=%b addr=%h",
               e.name, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
      n_fail++;
    end
    n_checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      $display("FAIL reset_counters: got stall=%0d flush=%0d, required 0 0",
               stall_count, flush_count);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 32'h0, 0, 0, 0, 0));
    exp_q.push_back('{C_DEF, 32'h0, "post_reset_default"});
    #2;
    e = exp_q.pop_front();
    n_checks++;
    if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
      $display("FAIL %s: got ctrl=%b addr=%h, required ctrl=%b addr=%h",
               e.name, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
      n_fail++;
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    stim_t s[5];
    logic [7:0] c[5];
    string nm[5];
    exp_t e;
    logic [31:0] base;
    s[0] = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, 0, 0); c[0] = C_LU;  nm[0] = "lu_rs1";
    s[1] = mk(5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0); c[1] = C_DEF; nm[1] = "lu_after_bubble";
    s[2] = mk(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, 0, 0, 0); c[2] = C_DEF; nm[2] = "lu_x0_no_stall";
    s[3] = mk(5'd1, 5'd9, 1, 1, 1, 5'd9, 0, 0, 0, 0, 0, 0); c[3] = C_LU;  nm[3] = "lu_rs2";
    s[4] = mk(5'd1, 5'd9, 1, 0, 1, 5'd9, 0, 0, 0, 0, 0, 0); c[4] = C_DEF; nm[4] = "lu_rs2_unused";
    base = stall_count;
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      exp_q.push_back('{c[i], 32'h0, nm[i]});
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
        $display("FAIL %s: got ctrl=%b addr=%h, required ctrl=%b addr=%h",
                 e.name, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
        n_fail++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (stall_count - base !== 32'd2) begin
      $display("FAIL lu_stall_count: got delta %0d, required 2", stall_count - base);
      n_fail++;
    end
  endtask

  task automatic test_clean_redirect();
    exp_t e;
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 32'h60, 1, 1, 0, 0));
    exp_q.push_back('{C_BR, 32'h60, "clean_redirect"});
    #2;
    e = exp_q.pop_front();
    n_checks++;
    if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
      $display("FAIL %s: got ctrl=%b addr=%h, required ctrl=%b addr=%h",
               e.name, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (flush_count !== 32'd1) begin
      $display("FAIL clean_flush_count: got %0d, required 1", flush_count);
      n_fail++;
    end
  endtask

  task automatic test_deferred_redirect();
    stim_t s[5];
    logic [7:0] c[5];
    logic [31:0] a[5];
    string nm[5];
    exp_t e;
    logic [31:0] sbase, fbase;
    s[0] = mk(0, 0, 0, 0, 0, 0, 1, 32'h80, 1, 0, 0, 0); c[0] = C_BRMS; a[0] = 0;     nm[0] = "defer_branch_miss";
    s[1] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 0); c[1] = C_SQW;  a[1] = 0;     nm[1] = "defer_squash_1";
    s[2] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 0); c[2] = C_SQW;  a[2] = 0;     nm[2] = "defer_squash_2";
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 1, 0, 0); c[3] = C_SQR;  a[3] = 32'h80; nm[3] = "defer_resp";
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 1, 0, 0); c[4] = C_DEF;  a[4] = 0;     nm[4] = "defer_after";
    sbase = stall_count;
    fbase = flush_count;
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      exp_q.push_back('{c[i], a[i], nm[i]});
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
        $display("FAIL %s: got ctrl=%b addr=%h, required ctrl=%b addr=%h",
                 e.name, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
        n_fail++;
      end
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (dut.state_q !== ISQUASH) begin
          $display("FAIL defer_state: got %0d, required ISQUASH", dut.state_q);
          n_fail++;
        end
      end
    end
    n_checks++;
    if (stall_count - sbase !== 32'd3 || flush_count - fbase !== 32'd1) begin
      $display("FAIL defer_counts: got stall delta %0d flush delta %0d, required 3 1",
               stall_count - sbase, flush_count - fbase);
      n_fail++;
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    logic [31:0] sbase, fbase;
    sbase = stall_count;
    fbase = flush_count;
    for (int i = 0; i < 5; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 1, 32'h44, 1, 1, 1, (i == 4)));
      if (i < 4) exp_q.push_back('{C_OFF, 32'h0, "freeze_hold"});
      else       exp_q.push_back('{C_BR, 32'h44, "freeze_release"});
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
        $display("FAIL %s: cycle %0d got ctrl=%b addr=%h, required ctrl=%b addr=%h",
                 e.name, i, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
        n_fail++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (stall_count - sbase !== 32'd4 || flush_count - fbase !== 32'd1) begin
      $display("FAIL freeze_counts: got stall delta %0d flush delta %0d, required 4 1",
               stall_count - sbase, flush_count - fbase);
      n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    apply(mk(5'd7, 5'd0, 1, 0, 1, 5'd7, 1, 32'h1234, 1, 1, 0, 0));
    exp_q.push_back('{C_BR, 32'h1234, "lu_and_branch"});
    #2;
    e = exp_q.pop_front();
    n_checks++;
    if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
      $display("FAIL %s: got ctrl=%b addr=%h, required ctrl=%b addr=%h",
               e.name, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
      n_fail++;
    end
    @(negedge clk);
  endtask

  task automatic test_imiss();
    stim_t s[4];
    logic [7:0] c[4];
    exp_t e;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); c[0] = C_IMISS;
    s[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); c[1] = C_IMISS;
    s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); c[2] = C_DEF;
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[3] = C_DEF;
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      exp_q.push_back('{c[i], 32'h0, "imiss_seq"});
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
        $display("FAIL %s: cycle %0d got ctrl=%b addr=%h, required ctrl=%b addr=%h",
                 e.name, i, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
        n_fail++;
      end
      @(negedge clk);
      if (i == 1) begin
        n_checks++;
        if (dut.state_q !== IWAIT) begin
          $display("FAIL imiss_state: got %0d, required IWAIT", dut.state_q);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_reset_in_squash();
    exp_t e;
    apply(mk(0, 0, 0, 0, 0, 0, 1, 32'hA0, 1, 0, 0, 0));
    @(negedge clk);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    exp_q.push_back('{C_SQW, 32'h0, "squash_before_reset"});
    #2;
    e = exp_q.pop_front();
    n_checks++;
    if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
      $display("FAIL %s: got ctrl=%b addr=%h, required ctrl=%b addr=%h",
               e.name, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
      n_fail++;
    end
    // Assert reset between edges: outputs and counters must clear at once
    rst = 1'b1;
    exp_q.push_back('{C_OFF, 32'h0, "async_reset_outputs"});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
      $display("FAIL %s: got ctrl=%b addr=%h, required ctrl=%b addr=%h",
               e.name, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
      n_fail++;
    end
    n_checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0 || dut.state_q !== RUN) begin
      $display("FAIL async_reset_state: got stall=%0d flush=%0d state=%0d, required 0 0 RUN",
               stall_count, flush_count, dut.state_q);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    exp_q.push_back('{C_DEF, 32'h0, "no_redirect_after_reset"});
    #2;
    e = exp_q.pop_front();
    n_checks++;
    if ({ctrl_vec, pc_redirect_addr} !== {e.ctrl, e.addr}) begin
      $display("FAIL %s: got ctrl=%b addr=%h, required ctrl=%b addr=%h",
               e.name, ctrl_vec, pc_redirect_addr, e.ctrl, e.addr);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (flush_count !== 32'd0 || stall_count !== 32'd0) begin
      $display("FAIL post_reset_counts: got stall=%0d flush=%0d, required 0 0",
               stall_count, flush_count);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_clean_redirect();
    test_deferred_redirect();
    test_freeze();
    test_simultaneous();
    test_imiss();
    test_reset_in_squash();
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core. It decides each cycle which pipeline registers load, which receive bubbles, and when the PC is redirected. The decision covers data-cache freezes, instruction-cache misses, load-use hazards and taken branches or jumps resolved in EX. It owns a small state machine and a target buffer so that a redirect arriving during an outstanding instruction fetch is deferred until that fetch completes.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2
- idex_mem_read  in  1  instruction in EX is a load
- idex_rd  in  5  destination register of the EX instruction
- ex_br_taken  in  1  EX resolved a taken branch or jump
- ex_br_target  in  32  redirect target from EX
- imem_read, imem_resp  in  1 each  instruction-cache request and response
- dmem_access, dmem_resp  in  1 each  MEM-stage data-cache request and response
- load_pc, load_ifid, load_idex, load_exmem, load_memwb  out  1 each  pipeline register enables
- flush_ifid, flush_idex  out  1 each  register loads a NOP bubble (only meaningful with its load)
- pc_redirect  out  1  PC mux selects pc_redirect_addr
- pc_redirect_addr  out  32  redirect target
- stall_count, flush_count  out  32 each  performance counters

## Operation
States (enum): RUN, IWAIT (fetch miss outstanding), ISQUASH (fetch miss outstanding, redirect pending). Definitions used below:
- imiss = imem_read && !imem_resp
- dfreeze = dmem_access && !dmem_resp
- lu = idex_mem_read && idex_rd != 0 && ((id_uses_rs1 && ifid_rs1 == idex_rd) || (id_uses_rs2 && ifid_rs2 == idex_rd))

The default is all loads = 1, flushes = 0, pc_redirect = 0. Rules are applied in priority order:
1. **dfreeze.** All loads = 0, flushes = 0, pc_redirect = 0. State, target and flush_count hold. ex_br_taken is ignored because EX holds and re-presents it. imem_resp is ignored; the cache keeps the request and hits later.
2. **ISQUASH.**
   - Without imem_resp: load_pc = 0, flush_ifid = 1.
   - With imem_resp: load_pc = 1, pc_redirect = 1, pc_redirect_addr = latched target, flush_ifid = 1, next state RUN.
   - Downstream stages always advance.
3. **ex_br_taken, no imiss.** load_pc = 1, pc_redirect = 1, pc_redirect_addr = ex_br_target, flush_ifid = 1, flush_idex = 1, next state RUN.
4. **ex_br_taken with imiss.** Latch ex_br_target, load_pc = 0, flush_ifid = 1, flush_idex = 1, next state ISQUASH.
5. **lu.** load_pc = 0, load_ifid = 0, flush_idex = 1, downstream loads = 1.
6. **imiss.** load_pc = 0, flush_ifid = 1, next state IWAIT. On imem_resp in IWAIT, next state RUN with the default outputs.

Additional rules:
- Redirect beats a simultaneous load-use hazard, because the ID instruction is squashed.
- ex_br_taken in ISQUASH cannot occur, since EX holds bubbles; the bench asserts this.
- pc_redirect_addr is driven as 0 when pc_redirect = 0.
- stall_count increments each non-reset cycle with load_pc = 0.
- flush_count increments each cycle pc_redirect = 1.
- Both counters wrap modulo 2^32.

## Timing
- All control outputs are combinational from state plus inputs in the same cycle: zero latency.
- State, target register and counters update on the rising clk edge.
- Reset:
  - state = RUN, target = 0, counters = 0.
  - While rst is high, all loads, flushes and pc_redirect = 0, and pc_redirect_addr = 0.
  - Reset mid-ISQUASH discards the pending redirect.
- Deferred redirect latency: the redirect is taken in the same cycle imem_resp arrives (ISQUASH exit), unless dfreeze holds it.
- A load-use hazard costs exactly 1 bubble when no other stall is present.

## Structure
- Shared package ctrl_types gets hz_state_t {RUN, IWAIT, ISQUASH}.
- Sub-module load_use_detect: combinational lu comparator, reusable by a later forwarding unit.
- The top level holds the FSM, the 32-bit target register, the two counters and the priority output logic.

## Test plan
- **Load-use.** lw x5 in EX, ID reads rs1 = x5 → one cycle with load_pc = 0, load_ifid = 0, flush_idex = 1; same case with idex_rd = x0 → no stall.
- **Clean redirect.** ex_br_taken with target 0x60 and imem hit → pc_redirect = 1, addr 0x60, flush_ifid = flush_idex = 1, flush_count 0 → 1.
- **Deferred redirect.** ex_br_taken with target 0x80 while imiss, then imem_resp 3 cycles later:
  - state goes to ISQUASH, then flush_ifid is held for 3 cycles;
  - on the resp cycle, pc_redirect = 1 with addr 0x80;
  - stall_count increases by 3.
- **Freeze.** dfreeze for 4 cycles overlapping ex_br_taken → all loads 0 and no redirect for 4 cycles; redirect occurs in cycle 5.
- **Simultaneous hazards.** lu and ex_br_taken in the same cycle → redirect outputs only, load_ifid = 1 with flush_ifid = 1.
- **Reset.** Assert rst asynchronously in ISQUASH → outputs go low immediately; after release state is RUN, counters are 0 and no redirect is issued on the next imem_resp.
